hb_run_controller: RTL and testbench

//  Sequences the birthday transmit/receive datapath. Accepts run requests from a manual

---
 rtl/hb_pkg.sv | 30 +++
 rtl/hb_run_controller_if.sv | 49 ++++
 rtl/hb_tick_gen.sv | 36 +++
 rtl/hb_run_controller.sv | 159 +++++++++++++++
 tb/tb_hb_run_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hb_pkg.sv
// Shared definitions for the happy-birthday run sequencing logic:
// FSM state encoding, default timing constants and widths.
package hb_pkg;

  localparam int unsigned DEF_BURST_CYCLES  = 256;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;
  localparam int unsigned DEF_GAP_CYCLES    = 16;
  localparam int unsigned DEF_AUTO_PERIOD   = 10000;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned RUN_CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } hb_state_t;

  // Largest of three widths; used to size the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hb_run_controller_if.sv
// Board-side request/result bundle for the run controller.
// master: board inputs / receiver side; slave: the controller itself.
interface hb_run_controller_if
  import hb_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic                 i_start;
  logic                 i_auto_en;
  logic                 i_abort;
  logic                 o_tx_en_n;
  logic [CNT_W-1:0]     i_hit_count;
  logic                 i_hit_count_valid;
  logic [CNT_W-1:0]     o_result;
  logic                 o_result_valid;
  logic                 o_busy;
  logic                 o_timeout;
  logic [RUN_CNT_W-1:0] o_run_count;

  modport master (
    output i_start,
    output i_auto_en,
    output i_abort,
    output i_hit_count,
    output i_hit_count_valid,
    input  o_tx_en_n,
    input  o_result,
    input  o_result_valid,
    input  o_busy,
    input  o_timeout,
    input  o_run_count
  );

  modport slave (
    input  i_start,
    input  i_auto_en,
    input  i_abort,
    input  i_hit_count,
    input  i_hit_count_valid,
    output o_tx_en_n,
    output o_result,
    output o_result_valid,
    output o_busy,
    output o_timeout,
    output o_run_count
  );

endinterface

// File: rtl/hb_tick_gen.sv
// Periodic auto-tick divider. Counts 0..AUTO_PERIOD-1 while enabled and
// emits a registered one-cycle tick when the count wraps; held at 0 when
// disabled.
module hb_tick_gen
  import hb_pkg::*;
#(
  parameter int unsigned AUTO_PERIOD = DEF_AUTO_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned TW = $clog2(AUTO_PERIOD + 1);

  logic [TW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == TW'(AUTO_PERIOD - 1));

  // Divider counter and registered tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (!i_en) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= wrap;
      cnt    <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hb_run_controller.sv
// Run sequencer for the birthday TX/RX datapath: arbitrates manual and
// auto run requests, drives the active-low TX enable for a fixed burst,
// waits for a rising receiver valid (with timeout), latches the hit count,
// then enforces an idle gap before the next grant.
module hb_run_controller
  import hb_pkg::*;
#(
  parameter int unsigned BURST_CYCLES  = DEF_BURST_CYCLES,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned AUTO_PERIOD   = DEF_AUTO_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hb_run_controller_if.slave  bus
);

  // One counter serves TX, DRAIN and GAP since the phases never overlap.
  localparam int unsigned CW = max3($clog2(BURST_CYCLES + 1),
                                    $clog2(DRAIN_TIMEOUT + 1),
                                    $clog2(GAP_CYCLES + 1));

  hb_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 pend_man, pend_man_n;
  logic                 pend_auto, pend_auto_n;
  logic                 valid_q;
  logic                 auto_tick;

  logic                 req_man, req_auto;
  logic                 grant;
  logic                 hit_edge;
  logic                 capture;
  logic                 timeout_set;

  logic                 tx_en_n_q;
  logic [CNT_W-1:0]     result_q;
  logic                 result_valid_q;
  logic                 busy_q;
  logic                 timeout_q;
  logic [RUN_CNT_W-1:0] run_count_q;

  hb_tick_gen #(
    .AUTO_PERIOD (AUTO_PERIOD)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.i_auto_en),
    .o_tick  (auto_tick)
  );

  // Next-state, counter, pending-flag and event decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    grant       = 1'b0;
    capture     = 1'b0;
    timeout_set = 1'b0;
    req_man     = pend_man | bus.i_start;
    req_auto    = pend_auto | auto_tick;
    pend_man_n  = req_man;
    pend_auto_n = req_auto;
    hit_edge    = bus.i_hit_count_valid & ~valid_q;

    if (bus.i_abort) begin
      // Abort dominates everything: no grant, no capture, requests dropped.
      state_n     = IDLE;
      pend_man_n  = 1'b0;
      pend_auto_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_man || req_auto) begin
            grant   = 1'b1;
            state_n = TX;
            cnt_n   = CW'(BURST_CYCLES - 1);
            if (req_man) pend_man_n  = 1'b0;
            else         pend_auto_n = 1'b0;
          end
        end
        TX: begin
          if (cnt == '0) begin
            state_n = DRAIN;
            cnt_n   = CW'(DRAIN_TIMEOUT - 1);
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        DRAIN: begin
          // Edge is tested first so it wins over a same-cycle timeout.
          if (hit_edge) begin
            capture = 1'b1;
            state_n = GAP;
            cnt_n   = CW'(GAP_CYCLES - 1);
          end else if (cnt == '0) begin
            timeout_set = 1'b1;
            state_n     = GAP;
            cnt_n       = CW'(GAP_CYCLES - 1);
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state_n = IDLE;
          else           cnt_n   = cnt - 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state, phase counter, pending flags and valid history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_man  <= 1'b0;
      pend_auto <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend_man  <= pend_man_n;
      pend_auto <= pend_auto_n;
      valid_q   <= bus.i_hit_count_valid;
    end
  end

  // Registered outputs, derived from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_en_n_q      <= 1'b1;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      run_count_q    <= '0;
    end else begin
      tx_en_n_q      <= (state_n != TX);
      busy_q         <= (state_n != IDLE);
      result_valid_q <= capture;
      if (capture) begin
        result_q    <= bus.i_hit_count;
        run_count_q <= run_count_q + 1'b1;
      end
      if (grant)            timeout_q <= 1'b0;
      else if (timeout_set) timeout_q <= 1'b1;
    end
  end

  assign bus.o_tx_en_n      = tx_en_n_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_timeout      = timeout_q;
  assign bus.o_run_count    = run_count_q;

endmodule

// File: tb/tb_hb_run_controller.sv
// Directed bench for hb_run_controller with short timing parameters.
module tb_hb_run_controller;
  import hb_pkg::*;

  localparam int unsigned CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned rv_cnt   = 0;

  hb_run_controller_if #(.CNT_W(CW)) bus ();

  hb_run_controller #(
    .BURST_CYCLES  (8),
    .DRAIN_TIMEOUT (20),
    .GAP_CYCLES    (4),
    .AUTO_PERIOD   (50),
    .CNT_W         (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Count result_valid pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.o_result_valid) rv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int unsigned limit, output bit ok);
    int unsigned k;
    k = 0;
    while (bus.o_busy && k < limit) begin
      step(1);
      k++;
    end
    ok = !bus.o_busy;
  endtask

  task automatic do_run(input logic [CW-1:0] val, output bit ok);
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    step(8);
    bus.i_hit_count       = val;
    bus.i_hit_count_valid = 1'b1;
    step(1);
    bus.i_hit_count_valid = 1'b0;
    wait_idle(20, ok);
    step(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned rv_before;
    int unsigned nrx;
    logic        tx_prev;
    bit          ok;
    bit          all_ok;

    bus.i_start           = 1'b0;
    bus.i_auto_en         = 1'b0;
    bus.i_abort           = 1'b0;
    bus.i_hit_count       = '0;
    bus.i_hit_count_valid = 1'b0;

    // Reset values
    step(3);
    check_eq("rst_tx_en_n", bus.o_tx_en_n, 1);
    check_eq("rst_result", bus.o_result, 0);
    check_eq("rst_result_valid", bus.o_result_valid, 0);
    check_eq("rst_busy", bus.o_busy, 0);
    check_eq("rst_timeout", bus.o_timeout, 0);
    check_eq("rst_run_count", bus.o_run_count, 0);
    rst_n = 1'b1;
    step(2);
    check_eq("idle_no_req_busy", bus.o_busy, 0);

    // 1: single manual run, valid 3 clocks after TX
    rv_before = rv_cnt;
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    check_eq("t1_tx_first_low", bus.o_tx_en_n, 0);
    check_eq("t1_busy", bus.o_busy, 1);
    step(7);
    check_eq("t1_tx_last_low", bus.o_tx_en_n, 0);
    step(1);
    check_eq("t1_tx_high_after", bus.o_tx_en_n, 1);
    step(2);
    bus.i_hit_count       = 16'd5;
    bus.i_hit_count_valid = 1'b1;
    step(1);
    check_eq("t1_result_valid", bus.o_result_valid, 1);
    check_eq("t1_result", bus.o_result, 5);
    check_eq("t1_run_count", bus.o_run_count, 1);
    bus.i_hit_count_valid = 1'b0;
    step(1);
    check_eq("t1_result_valid_drop", bus.o_result_valid, 0);
    step(2);
    check_eq("t1_busy_in_gap", bus.o_busy, 1);
    step(1);
    check_eq("t1_idle_after_gap", bus.o_busy, 0);
    check_eq("t1_rv_pulses", rv_cnt - rv_before, 1);

    // 2: manual and auto-tick in the same IDLE cycle
    bus.i_auto_en = 1'b1;
    step(50);
    bus.i_start = 1'b1;
    step(1);
    bus.i_start   = 1'b0;
    bus.i_auto_en = 1'b0;
    check_eq("t2_run1_tx", bus.o_tx_en_n, 0);
    step(8);
    check_eq("t2_run1_drain", bus.o_tx_en_n, 1);
    bus.i_hit_count       = 16'd11;
    bus.i_hit_count_valid = 1'b1;
    step(1);
    check_eq("t2_run1_result", bus.o_result, 11);
    bus.i_hit_count_valid = 1'b0;
    step(4);
    check_eq("t2_idle_between_busy", bus.o_busy, 0);
    check_eq("t2_idle_between_tx", bus.o_tx_en_n, 1);
    step(1);
    check_eq("t2_run2_tx", bus.o_tx_en_n, 0);
    check_eq("t2_run2_busy", bus.o_busy, 1);
    step(8);
    bus.i_hit_count       = 16'd22;
    bus.i_hit_count_valid = 1'b1;
    step(1);
    check_eq("t2_run2_result", bus.o_result, 22);
    check_eq("t2_run_count", bus.o_run_count, 3);
    bus.i_hit_count_valid = 1'b0;
    wait_idle(20, ok);
    check_eq("t2_wait_idle", ok, 1);
    step(3);
    check_eq("t2_no_third_run", bus.o_busy, 0);

    // 3: DRAIN timeout
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    step(8);
    step(19);
    check_eq("t3_no_timeout_yet", bus.o_timeout, 0);
    check_eq("t3_still_draining", bus.o_busy, 1);
    step(1);
    check_eq("t3_timeout_set", bus.o_timeout, 1);
    check_eq("t3_result_held", bus.o_result, 22);
    check_eq("t3_run_count_held", bus.o_run_count, 3);
    wait_idle(20, ok);
    check_eq("t3_wait_idle", ok, 1);
    check_eq("t3_timeout_sticky", bus.o_timeout, 1);

    // 4: valid high through TX into DRAIN needs a fresh rising edge
    bus.i_hit_count       = 16'd33;
    bus.i_hit_count_valid = 1'b1;
    bus.i_start           = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    check_eq("t4_grant_clears_timeout", bus.o_timeout, 0);
    rv_before = rv_cnt;
    step(8);
    step(3);
    bus.i_hit_count_valid = 1'b0;
    step(2);
    check_eq("t4_no_capture_on_level", rv_cnt - rv_before, 0);
    check_eq("t4_result_unchanged", bus.o_result, 22);
    bus.i_hit_count       = 16'd44;
    bus.i_hit_count_valid = 1'b1;
    step(1);
    check_eq("t4_result_valid", bus.o_result_valid, 1);
    check_eq("t4_result", bus.o_result, 44);
    check_eq("t4_run_count", bus.o_run_count, 4);
    bus.i_hit_count_valid = 1'b0;
    wait_idle(20, ok);
    check_eq("t4_wait_idle", ok, 1);
    step(1);

    // 5a: abort in TX cycle 4; a start during abort is dropped
    rv_before = rv_cnt;
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    step(3);
    check_eq("t5_tx_cycle4_low", bus.o_tx_en_n, 0);
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    step(1);
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    check_eq("t5_abort_tx_high", bus.o_tx_en_n, 1);
    check_eq("t5_abort_idle", bus.o_busy, 0);
    step(2);
    check_eq("t5_req_dropped", bus.o_busy, 0);
    check_eq("t5_no_result_valid", rv_cnt - rv_before, 0);
    check_eq("t5_run_count", bus.o_run_count, 4);

    // 5b: asynchronous reset in DRAIN
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    step(9);
    check_eq("t5_in_drain", bus.o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_arst_tx_en_n", bus.o_tx_en_n, 1);
    check_eq("t5_arst_result", bus.o_result, 0);
    check_eq("t5_arst_busy", bus.o_busy, 0);
    check_eq("t5_arst_run_count", bus.o_run_count, 0);
    check_eq("t5_arst_timeout", bus.o_timeout, 0);
    check_eq("t5_arst_result_valid", bus.o_result_valid, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // 6a: auto runs for 300 clocks with a responding receiver
    rv_before = rv_cnt;
    nrx       = 0;
    tx_prev   = bus.o_tx_en_n;
    bus.i_auto_en = 1'b1;
    for (int i = 0; i < 360; i++) begin
      if (i == 300) bus.i_auto_en = 1'b0;
      step(1);
      if (!tx_prev && bus.o_tx_en_n) begin
        nrx++;
        bus.i_hit_count       = 16'(16'h0100 + nrx);
        bus.i_hit_count_valid = 1'b1;
      end else begin
        bus.i_hit_count_valid = 1'b0;
      end
      tx_prev = bus.o_tx_en_n;
    end
    check_eq("t6_auto_run_count", bus.o_run_count, 6);
    check_eq("t6_auto_result", bus.o_result, 32'h0106);
    check_eq("t6_auto_rv_pulses", rv_cnt - rv_before, 6);
    check_eq("t6_auto_idle", bus.o_busy, 0);

    // 6b: run counter wraps 255 -> 0
    all_ok = 1'b1;
    for (int r = 0; r < 249; r++) begin
      do_run(16'(r), ok);
      all_ok &= ok;
    end
    check_eq("t6_wrap_runs_complete", all_ok, 1);
    check_eq("t6_run_count_255", bus.o_run_count, 255);
    do_run(16'd777, ok);
    check_eq("t6_last_run_complete", ok, 1);
    check_eq("t6_run_count_wrap", bus.o_run_count, 0);
    check_eq("t6_wrap_result", bus.o_result, 777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
